// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, defaults and round-robin helper for button event logic
package btn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    localparam int DEBOUNCE_LIMIT_DEF = 40;
    localparam int CNT_W_DEF          = 20;
    localparam int MAX_BTN            = 8;
    localparam int RR_W               = 3;

    // First set bit at or above ptr, wrapping modulo num; returns 0 when nothing is set.
    function automatic logic [RR_W-1:0] next_rr(input logic [MAX_BTN-1:0] pending,
                                                 input logic [RR_W-1:0]    ptr,
                                                 input int                 num);
        logic [RR_W-1:0] grant;
        logic            found;
        int              idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_BTN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if (k < num && !found && pending[idx[RR_W-1:0]]) begin
                grant = idx[RR_W-1:0];
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - single-channel counting debouncer for a pre-synchronised input
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Reaching the limit wins over both increment and clear, so the counter never wraps.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (cnt_q == CNT_W'(DEBOUNCE_LIMIT)) begin
            level_d = 1'b1;
            cnt_d   = '0;
        end else if (btn_in) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            level_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - debounced button edges queued as one-shot events, granted round-robin
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int  NUM_BTN        = 4,
    parameter int  DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
    parameter int  CNT_W          = CNT_W_DEF,
    localparam int ID_W           = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] overflow,
    input  logic               ovf_clr
);

    logic [NUM_BTN-1:0] level_prev_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] accept_vec;
    logic [NUM_BTN-1:0] ovf_set;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] overflow_q, overflow_d;
    arb_state_e         state_q;
    logic               evt_valid_q;
    logic [ID_W-1:0]    evt_id_q;
    logic [ID_W-1:0]    ptr_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_in   (btn_in[g]),
            .btn_level(btn_level[g])
        );
    end

    // A rise coinciding with acceptance of the same channel re-arms it instead of overflowing.
    always_comb begin
        rise       = btn_level & ~level_prev_q;
        accept_vec = '0;
        if (state_q == OFFER && evt_ready) begin
            accept_vec[evt_id_q] = 1'b1;
        end
        ovf_set    = rise & pending_q & ~accept_vec;
        pending_d  = (pending_q & ~accept_vec) | rise;
        overflow_d = (ovf_clr ? '0 : overflow_q) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
        end else begin
            level_prev_q <= btn_level;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        evt_id_q    <= ID_W'(next_rr(MAX_BTN'(pending_q), RR_W'(ptr_q), NUM_BTN));
                        evt_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        evt_valid_q <= 1'b0;
                        ptr_q       <= (evt_id_q == ID_W'(NUM_BTN - 1)) ? '0 : evt_id_q + ID_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - self-checking bench with behavioural model for btn_event_arbiter
module tb_btn_event_arbiter;

    localparam int N   = 4;
    localparam int LIM = 40;
    localparam int CW  = 20;
    localparam int IW  = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [N-1:0]  btn_in    = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic [N-1:0]  btn_level;
    logic [N-1:0]  overflow;
    logic          evt_valid;
    logic [IW-1:0] evt_id;

    btn_event_arbiter #(
        .NUM_BTN       (N),
        .DEBOUNCE_LIMIT(LIM),
        .CNT_W         (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer counters, flag arrays and modulo search.
    int m_cnt  [N];
    bit m_lvl  [N];
    bit m_prev [N];
    bit m_pend [N];
    bit m_ovf  [N];
    bit m_valid;
    int m_id;
    int m_ptr;
    bit r_rise [N];
    bit r_oldp [N];
    bit r_acc;
    bit r_clr;
    int r_g;

    function automatic logic [N-1:0] pack(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_valid = 0; m_id = 0; m_ptr = 0;
        end else begin
            r_acc = m_valid && evt_ready;
            for (int i = 0; i < N; i++) begin
                r_rise[i] = m_lvl[i] && !m_prev[i];
                r_oldp[i] = m_pend[i];
            end
            for (int i = 0; i < N; i++) begin
                r_clr = r_acc && (m_id == i);
                if (r_rise[i] && m_pend[i] && !r_clr) m_ovf[i] = 1;
                else if (ovf_clr) m_ovf[i] = 0;
                m_pend[i] = (m_pend[i] && !r_clr) || r_rise[i];
            end
            if (m_valid) begin
                if (evt_ready) begin
                    m_valid = 0;
                    m_ptr   = (m_id + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    r_g = (m_ptr + k) % N;
                    if (!m_valid && r_oldp[r_g]) begin
                        m_valid = 1;
                        m_id    = r_g;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                m_prev[i] = m_lvl[i];
                if (m_cnt[i] == LIM) begin
                    m_lvl[i] = 1; m_cnt[i] = 0;
                end else if (btn_in[i]) begin
                    m_cnt[i]++;
                end else begin
                    m_lvl[i] = 0; m_cnt[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_level", 32'(btn_level), 32'(pack(m_lvl)));
            check("cmp_valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) check("cmp_id", 32'(evt_id), m_id);
            check("cmp_ovf", 32'(overflow), 32'(pack(m_ovf)));
        end
    end

    logic [IW-1:0] hs_q[$];
    always @(posedge clk) begin
        if (rst_n && evt_valid && evt_ready) hs_q.push_back(evt_id);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (evt_valid !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        check(name, 32'(evt_valid), 1);
    endtask

    task automatic check_order(input string name, input int exp0, input int exp1, input int exp2, input int cnt);
        int e[3];
        e[0] = exp0; e[1] = exp1; e[2] = exp2;
        check({name, "_count"}, hs_q.size(), cnt);
        for (int k = 0; k < cnt && k < hs_q.size(); k++)
            check($sformatf("%s_%0d", name, k), 32'(hs_q[k]), e[k]);
    endtask

    bit held_ok;
    bit stale;

    initial begin
        #1;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_level", 32'(btn_level), 0);
        check("rst_ovf",   32'(overflow), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        btn_in[0] = 1'b1;
        tick(40);
        check("rise_edge40", 32'(btn_level[0]), 0);
        tick(1);
        check("rise_edge41", 32'(btn_level[0]), 1);
        check("model_edge41", 32'(m_lvl[0]), 1);
        tick(1);
        check("grant_edge42", 32'(evt_valid), 0);
        tick(1);
        check("grant_edge43_valid", 32'(evt_valid), 1);
        check("grant_edge43_id", 32'(evt_id), 0);
        btn_in[0] = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        check("hs_clear", 32'(evt_valid), 0);
        evt_ready = 1'b0;
        tick(3);

        btn_in[1] = 1'b1; tick(39);
        btn_in[1] = 1'b0; tick(1);
        btn_in[1] = 1'b1; tick(39);
        btn_in[1] = 1'b0; tick(5);
        check("glitch_level", 32'(btn_level[1]), 0);
        check("glitch_noevt", 32'(evt_valid), 0);

        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        hs_q.delete();
        evt_ready = 1'b1;
        btn_in = 4'b1101; tick(60);
        btn_in = 4'b0000; tick(10);
        check_order("rr_first", 0, 2, 3, 3);
        hs_q.delete();
        btn_in = 4'b1001; tick(60);
        btn_in = 4'b0000; tick(10);
        check_order("rr_wrap", 0, 3, 0, 2);

        evt_ready = 1'b0;
        hs_q.delete();
        btn_in[1] = 1'b1;
        wait_valid("bp_offer");
        btn_in[1] = 1'b0;
        held_ok = 1'b1;
        repeat (100) begin
            tick(1);
            if (evt_valid !== 1'b1 || evt_id !== 2'd1) held_ok = 1'b0;
        end
        check("bp_held", 32'(held_ok), 1);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        check("bp_hs", hs_q.size(), 1);
        check("bp_valid_drop", 32'(evt_valid), 0);
        tick(5);
        check("bp_pend_clear", 32'(evt_valid), 0);

        hs_q.delete();
        btn_in[2] = 1'b1;
        wait_valid("ovf_first");
        check("ovf_first_id", 32'(evt_id), 2);
        btn_in[2] = 1'b0; tick(2);
        btn_in[2] = 1'b1; tick(45);
        btn_in[2] = 1'b0; tick(2);
        check("ovf_set", 32'(overflow), 32'h4);
        evt_ready = 1'b1; tick(10); evt_ready = 1'b0;
        check("ovf_one_event", hs_q.size(), 1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        btn_in[3] = 1'b1;
        wait_valid("arst_offer");
        check("arst_level_before", 32'(btn_level[3]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(evt_valid), 0);
        check("arst_level", 32'(btn_level), 0);
        btn_in = '0;
        tick(2);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (60) begin
            tick(1);
            if (evt_valid !== 1'b0) stale = 1'b1;
        end
        check("arst_no_stale", 32'(stale), 0);

        for (int c = 0; c < 6000; c++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 69) == 0) btn_in[ch] = ~btn_in[ch];
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        btn_in = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
Debounces NUM_BTN raw push-button or switch inputs and turns each debounced rising edge into a one-shot event. Pending events from all channels share a single downstream command port and are granted round-robin over a valid/ready handshake. Sits between the board buttons and the SPI accelerometer command sequencer, e.g. for "start read", "change range" and "recalibrate" requests.

Parameters:
NUM_BTN, 4, number of button channels (2..8)
DEBOUNCE_LIMIT, 40, consecutive high samples required before the debounced level rises
CNT_W, 20, debounce counter width; must satisfy DEBOUNCE_LIMIT < 2**CNT_W
ID_W, $clog2(NUM_BTN), event id width (derived, not overridable)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  reset, asynchronous assert, active-low
btn_in  in  NUM_BTN  raw inputs, already synchronised to clk upstream
btn_level  out  NUM_BTN  debounced level per channel
evt_valid  out  1  event offered to consumer
evt_id  out  ID_W  channel index of offered event
evt_ready  in  1  consumer accepts event when high with evt_valid
overflow  out  NUM_BTN  sticky: new edge arrived while channel already pending
ovf_clr  in  1  synchronous clear of all overflow bits

Behaviour:
- Reset (rst_n=0): all counters 0; btn_level, pending, overflow, evt_valid, evt_id = 0; round-robin pointer = 0, so channel 0 has top priority first. State is IDLE.
- Per-channel debounce, per clock edge:
  - btn_in[i]=1: counter increments.
  - counter==DEBOUNCE_LIMIT: btn_level[i]<=1 and counter<=0. This has priority over the increment.
  - Otherwise, if btn_in[i]=0: btn_level[i]<=0 and counter<=0.
  - Rise latency: with btn_in high continuously from edge 1, btn_level rises at edge DEBOUNCE_LIMIT+1.
  - Fall latency: a single low sample clears btn_level on the next edge.
  - Counter never wraps.
- Edge detect: rise[i] = btn_level[i] & ~btn_level_d[i] (registered copy). rise is one cycle wide. A channel held high never re-fires.
- Pending: rise[i] sets pending[i].
  - rise[i] while pending[i] is already 1 and not being cleared this cycle: overflow[i]<=1. Pending stays 1 and the event count is not incremented; events coalesce.
  - rise[i] in the same cycle that channel i's event is accepted: pending[i] stays 1 and no overflow.
  - ovf_clr and a new overflow in the same cycle: set wins.
- Arbiter FSM:
  - IDLE: if any pending bit is set, select the first set bit searching upward from ptr, wrapping modulo NUM_BTN. Register evt_id, set evt_valid=1, go to OFFER. Grant latency is 1 cycle from pending being visible.
  - OFFER: evt_valid and evt_id are held stable until evt_valid&evt_ready. On handshake: clear pending[evt_id], ptr<=(evt_id+1) mod NUM_BTN, evt_valid<=0, return to IDLE.
  - Maximum throughput is one event per 2 cycles. Back-to-back offers are not required.
  - evt_ready while in IDLE is ignored.
- Requirements on the consumer: evt_ready may be held high continuously. Dropping evt_valid without a handshake is forbidden.
- Reset mid-operation: an asynchronous rst_n drop discards all pending events and any event in flight. evt_valid drops immediately.
- Unused ids (NUM_BTN not a power of 2) are never produced.

Decomposition:
- Shared package btn_pkg:
  - state enum {IDLE, OFFER}.
  - Function next_rr(pending, ptr) returning the granted index.
  - Default constants DEBOUNCE_LIMIT_DEF=40 and CNT_W_DEF=20. The accelerometer top level reuses these.
- One sub-module: btn_debounce_ch (clk, rst_n, btn_in, btn_level; parameters DEBOUNCE_LIMIT, CNT_W), instantiated NUM_BTN times via generate.
- Edge detect, pending, overflow and arbiter logic stay in the top.

Test Plan:
- Debounce rise: DEBOUNCE_LIMIT=40, hold btn_in[0]=1 -> btn_level[0] rises exactly at edge 41. evt_valid=1 with evt_id=0 one cycle after pending sets.
- Glitch rejection: pulse btn_in[1] high for 39 cycles, low for 1, high for 39 -> btn_level[1] stays 0, no event.
- Round-robin: channels 0, 2 and 3 rise in the same cycle, evt_ready=1 -> events issued in order 0, 2, 3. A later simultaneous 0 and 3 gives 0 then 3, since ptr wrapped after 3.
- Backpressure: evt_ready=0 for 100 cycles -> evt_valid and evt_id held constant. Releasing ready gives exactly one handshake and pending clears.
- Overflow and coalescing: channel 2 rises twice while its event is unaccepted -> overflow[2]=1 and only one id-2 event is delivered. ovf_clr clears overflow[2].
- Async reset: assert rst_n=0 mid-OFFER between clock edges -> evt_valid and btn_level go 0 immediately. After release no stale event appears.
